// File: rtl/comparator_pkg.sv
// comparator_pkg: shared width default, compare-result encoding and flag decode helper
package comparator_pkg;
  localparam int WIDTH_DEFAULT = 4;
  typedef enum logic [1:0] {CMP_NONE, CMP_EQ, CMP_LT, CMP_GT} cmp_result_t;
  function automatic logic [2:0] decode_flags(input cmp_result_t r);
    return {r == CMP_EQ, r == CMP_LT, r == CMP_GT};
  endfunction
endpackage

// File: rtl/comparator_bit_slice.sv
// comparator_bit_slice: 1-bit magnitude cascade cell (eq/lt/gt from more significant slice in, cascaded out)
module comparator_bit_slice (
  input  logic a_bit,
  input  logic b_bit,
  input  logic eq_i,
  input  logic lt_i,
  input  logic gt_i,
  output logic eq_o,
  output logic lt_o,
  output logic gt_o
);
  assign eq_o = eq_i & (a_bit == b_bit);
  assign lt_o = lt_i | (eq_i & ~a_bit & b_bit);
  assign gt_o = gt_i | (eq_i & a_bit & ~b_bit);
endmodule

// File: rtl/comparator_4bits.sv
// comparator_4bits: registered WIDTH-bit magnitude comparator with one-hot equal/less/higher, 1-cycle latency
// ports: clk, rst_n (async active-low), in_valid, port_a, port_b -> equal, less, higher, out_valid
// COMPARATOR_SIGNED_EN adds signed_mode for two's-complement compare
module comparator_4bits
  import comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             equal,
  output logic             less,
  output logic             higher,
  output logic             out_valid
);
  logic [WIDTH:0] eq_c, lt_c, gt_c;
  logic sgn;
  cmp_result_t res_d, res_q;
  logic vld_q;
`ifdef COMPARATOR_SIGNED_EN
  assign sgn = signed_mode;
`else
  assign sgn = 1'b0;
`endif
  assign eq_c[WIDTH] = 1'b1;
  assign lt_c[WIDTH] = 1'b0;
  assign gt_c[WIDTH] = 1'b0;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_slice
      // a differing sign bit decides inversely, so swap operands at the MSB only
      logic sw;
      assign sw = sgn && (i == WIDTH - 1);
      comparator_bit_slice u_slice (
        .a_bit(sw ? port_b[i] : port_a[i]),
        .b_bit(sw ? port_a[i] : port_b[i]),
        .eq_i (eq_c[i+1]),
        .lt_i (lt_c[i+1]),
        .gt_i (gt_c[i+1]),
        .eq_o (eq_c[i]),
        .lt_o (lt_c[i]),
        .gt_o (gt_c[i])
      );
    end
  endgenerate
  always_comb
    res_d = !in_valid ? res_q : eq_c[0] ? CMP_EQ : lt_c[0] ? CMP_LT : gt_c[0] ? CMP_GT : CMP_NONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_q <= CMP_NONE;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= in_valid;
    end
  assign {equal, less, higher} = decode_flags(res_q);
  assign out_valid = vld_q;
endmodule

// File: tb/tb_comparator_4bits.sv
// tb_comparator_4bits: directed + exhaustive + random checks of comparator_4bits against an arithmetic model
module tb_comparator_4bits;
`ifdef COMPARATOR_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] port_a = '0, port_b = '0;
  logic sm = 1'b0;
  logic equal, less, higher, out_valid;
  logic [2:0] held = 3'b000;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  comparator_4bits #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .port_a(port_a), .port_b(port_b),
`ifdef COMPARATOR_SIGNED_EN
    .signed_mode(sm),
`endif
    .equal(equal), .less(less), .higher(higher), .out_valid(out_valid)
  );

  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y;
    x = int'(a);
    y = int'(b);
    if (s && SIGNED_EN) begin
      if (x >= 8) x -= 16;
      if (y >= 8) y -= 16;
    end
    return (x == y) ? 3'b100 : (x < y) ? 3'b010 : 3'b001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v, input logic s, input string tag);
    @(negedge clk);
    in_valid = v;
    port_a = a;
    port_b = b;
    sm = s;
    @(posedge clk);
    #1;
    if (v) held = model(a, b, s);
    check(tag, 32'({out_valid, equal, less, higher}), 32'({v, held}));
    if (v) check({tag, "_onehot"}, 32'($countones({equal, less, higher})), 32'd1);
  endtask

  logic [3:0] ua [9] = '{4'b0101, 4'b1000, 4'b0000, 4'b0011, 4'b0100, 4'b0111, 4'b1010, 4'b0100, 4'b0011};
  logic [3:0] ub [9] = '{4'b0000, 4'b1111, 4'b0001, 4'b0011, 4'b0100, 4'b0100, 4'b1011, 4'b0101, 4'b1011};
  logic [3:0] sa [3] = '{4'b0111, 4'b1000, 4'b1111};
  logic [3:0] sb [3] = '{4'b1000, 4'b1111, 4'b0000};

  initial begin
    #1;
    check("reset_state", 32'({out_valid, equal, less, higher}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 1'b1, 1'b0, "zero_zero");
    for (int i = 0; i < 9; i++) step(ua[i], ub[i], 1'b1, 1'b0, $sformatf("useq%0d", i));
    step(4'b1111, 4'b0000, 1'b1, 1'b0, "ones_zero");
    step(4'b0111, 4'b0100, 1'b1, 1'b0, "pre_hold");
    for (int i = 0; i < 3; i++) step(4'($urandom), 4'($urandom), 1'b0, 1'b0, $sformatf("hold%0d", i));
    step(4'b0001, 4'b0011, 1'b1, 1'b0, "pre_reset");
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    port_a = 4'b1111;
    port_b = 4'b0000;
    rst_n = 1'b0;
    #1;
    held = 3'b000;
    check("async_reset", 32'({out_valid, equal, less, higher}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 1'b1, 1'b0, "post_reset_eq");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(4'(a), 4'(b), 1'b1, 1'b0, $sformatf("exh_%0d_%0d", a, b));
    for (int i = 0; i < 3; i++) step(sa[i], sb[i], 1'b1, 1'b1, $sformatf("signed%0d", i));
    for (int i = 0; i < 3; i++) step(sa[i], sb[i], 1'b1, 1'b0, $sformatf("unsigned_pair%0d", i));
    for (int i = 0; i < 300; i++)
      step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), $sformatf("rand%0d", i));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/comparator_4bits.md
Name: comparator_4bits

Overview:
- Registered magnitude comparator for two WIDTH-bit operands, port_a and port_b (default 4 bits).
- Produces three mutually exclusive one-hot flags: equal, less (a<b) and higher (a>b).
- Used as a leaf compare stage in datapaths. Inputs are sampled on a valid strobe; results are presented one cycle later with out_valid.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  port_a/port_b are valid and are sampled this cycle.
- port_a  input  WIDTH  operand A.
- port_b  input  WIDTH  operand B.
- equal  output  1  registered: A == B.
- less  output  1  registered: A < B.
- higher  output  1  registered: A > B.
- out_valid  output  1  flags hold a result that was sampled on the previous clock edge.

Behaviour:
- Reset: rst_n low asynchronously clears equal, less, higher and out_valid to 0. This applies immediately, including mid-operation. The first sample is accepted on the first rising edge after rst_n rises.
- Latency: exactly 1 cycle. If in_valid is high at edge N, the flags and out_valid=1 are visible after edge N.
- No backpressure; a new operand pair may be presented every cycle at full throughput.
- in_valid low at an edge: out_valid goes to 0 and equal/less/higher hold their last values (no toggling).
- Invariant: whenever out_valid=1, exactly one of equal/less/higher is 1. After reset all three are 0.
- Default compare is unsigned magnitude.
  - MSB-first evaluation: the first differing bit decides.
  - higher when A's bit is 1 at that position.
  - less when A's bit is 0 at that position.
  - equal when no bit differs.
- Boundaries: all-zeros vs all-zeros gives equal. All-ones vs all-zeros gives higher. Only the LSB differing is enough to decide.
- Inputs containing X/Z are not defined; the verifier excludes them.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit, sampled with in_valid).
  - signed_mode=1: operands are compared as two's complement. A differing MSB decides inversely: A MSB=1 means less. Otherwise the remaining bits are compared unsigned.
  - signed_mode=0: identical to the unsigned default.
- Undefined: the signed_mode port does not exist; unsigned compare only.

Decomposition:
- Package comparator_pkg:
  - localparam WIDTH_DEFAULT=4.
  - typedef cmp_result_t: enum of CMP_NONE, CMP_EQ, CMP_LT, CMP_GT.
  - Helper function decoding cmp_result_t to the three flags.
- One sub-module, comparator_bit_slice:
  - 1-bit cascade cell.
  - Inputs: a_bit, b_bit, and incoming eq/lt/gt from the more significant slice.
  - Outputs: cascaded eq/lt/gt.
  - The top instantiates WIDTH slices MSB→LSB via generate. The sign override sits only at the MSB slice. The top registers the final cascade outputs.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 → all outputs 0 immediately; after release, port_a=0000/port_b=0000 → next cycle equal=1, less=0, higher=0, out_valid=1.
- Unsigned sequence back-to-back, one pair per cycle, each result one cycle later:
  - 0101/0000 → higher
  - 1000/1111 → less
  - 0000/0001 → less
  - 0011/0011 → equal
  - 0100/0100 → equal
  - 0111/0100 → higher
  - 1010/1011 → less
  - 0100/0101 → less
  - 0011/1011 → less
- Hold: after 0111/0100, drop in_valid for 3 cycles → out_valid=0 and higher stays 1.
- Exhaustive: all 256 pairs at WIDTH=4 compared against a reference model → exactly one flag set every result cycle.
- COMPARATOR_SIGNED_EN, signed_mode=1:
  - 0111/1000 → higher (7 > −8)
  - 1000/1111 → less (−8 < −1)
  - 1111/0000 → less
- Same pairs with signed_mode=0 → less, less, higher.
